frame_monitor: RTL and testbench
================================

FRAME_MONITOR -- requirements
Module: frame_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel/word width.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the frame length counter.
REQ-003 SHALL have parameter DROP_WIDTH, default 16, width of the dropped-word counter.
REQ-004 SHALL have ports: clk  in  1  single clock; one clock, reset is synchronous and active-high.
REQ-005 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: in_empty  in  1  upstream FIFO empty; in_din  in  DATA_WIDTH  upstream head word; in_sof, in_eof  in  1 each  head-word frame flags.
REQ-007 SHALL have ports: in_rd_en  out  1  pop upstream FIFO.
REQ-008 SHALL have ports: out_full  in  1  downstream FIFO full; out_wr_en  out  1  push downstream; out_dout  out  DATA_WIDTH; out_sof, out_eof  out  1 each.
REQ-009 SHALL have ports: stat_valid  out  1  one-cycle pulse per closed frame; stat_len  out  LEN_WIDTH; stat_sum  out  16  frame checksum; stat_err  out  1  frame aborted; drop_cnt  out  DROP_WIDTH  words discarded outside frames.

Function
REQ-010 SHALL treat the upstream FIFO as first-word-fall-through: in_din/in_sof/in_eof valid whenever in_empty=0; in_rd_en pops that word in the same cycle.
REQ-011 SHALL implement states IDLE (hunting SOF) and FRAME (forwarding).
REQ-012 IDLE: in_rd_en=!in_empty when head in_sof=0 (word discarded, drop_cnt+1, saturating); when head in_sof=1, in_rd_en=!in_empty&&!out_full and the word is forwarded.
REQ-013 FRAME: in_rd_en=!in_empty&&!out_full; every popped word forwarded.
REQ-014 Forwarding SHALL be combinational, zero latency: out_wr_en=in_rd_en for forwarded words, out_dout=in_din, out_sof=in_sof, out_eof=in_eof; out_wr_en SHALL never assert while out_full=1.
REQ-015 Transition IDLE->FRAME on forwarded SOF word without EOF; FRAME->IDLE on forwarded EOF word; SOF+EOF on one word in IDLE SHALL close a 1-word frame and stay IDLE.
REQ-016 SOF word popped while in FRAME SHALL close the current frame with stat_err=1 (length/sum excluding the new word) and open a new frame with that word in the same cycle.
REQ-017 stat_len SHALL count forwarded words of the frame incl. SOF and EOF words, saturating at 2^LEN_WIDTH-1.
REQ-018 stat_sum SHALL be the modulo-2^16 sum of zero-extended in_din over the frame.
REQ-019 stat_valid/stat_len/stat_sum/stat_err SHALL be registered, asserted the cycle after the closing pop, held until next closure; stat_valid high exactly one cycle.
REQ-020 EOF-flagged word popped in IDLE without SOF SHALL be discarded and counted in drop_cnt, no stat pulse.

Reset
REQ-021 reset SHALL force state IDLE, frame length and sum accumulators 0, stat_valid=0, stat_len=0, stat_sum=0, stat_err=0, drop_cnt=0.
REQ-022 reset mid-frame SHALL discard the partial frame with no stat pulse; in_rd_en and out_wr_en SHALL be 0 during reset.

Configuration
REQ-023 Macro FRAME_MONITOR_CHECKSUM_EN SHALL gate the checksum: defined -> REQ-018 behaviour; undefined -> no sum accumulator synthesized, stat_sum tied to 0.

Structure
REQ-024 Shared package frame_pkg SHALL hold the state enum typedef (IDLE, FRAME) and the checksum width constant (16).
REQ-025 No sub-module; single flat module.

Verification
REQ-026 Frame SOF,0x10,0x20,EOF-word 0x30 (SOF on 0x01), no backpressure -> 4 words forwarded unchanged, stat_valid 1 cycle after EOF pop, stat_len=4, stat_sum=0x0061, stat_err=0.
REQ-027 Three words 0xAA without SOF then frame -> 3 words popped not forwarded, drop_cnt=3, subsequent frame forwarded intact.
REQ-028 out_full=1 for 5 cycles mid-frame -> in_rd_en=0 and out_wr_en=0 those cycles, no word lost or duplicated, stat_len correct.
REQ-029 Frame of 3 words then new SOF without EOF -> stat_err=1, stat_len=3; new frame continues and closes normally with stat_err=0.
REQ-030 Single word with SOF=EOF=1, din=0x7F -> stat_len=1, stat_sum=0x007F, state remains IDLE.
REQ-031 reset asserted after 2 words of a frame -> no stat pulse, all outputs at reset values; next frame reports from zero; with FRAME_MONITOR_CHECKSUM_EN undefined stat_sum=0 throughout.

Source files
------------

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types and constants for the frame monitor
//
// Purpose: holds the monitor state enum and the checksum width so that the
//          RTL and any bench agree on both.
// Contents:
//   state_t    - IDLE (hunting for SOF) / FRAME (forwarding a frame)
//   CSUM_WIDTH - width of the frame checksum reported on stat_sum

package frame_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam int CSUM_WIDTH = 16;

endpackage

// File: rtl/frame_monitor.sv
// rtl/frame_monitor.sv - zero-latency FWFT frame forwarder with per-frame statistics
//
// Purpose: pops words from a first-word-fall-through FIFO and forwards framed
//          words straight to a downstream FIFO.  Words arriving outside a frame
//          are discarded and counted.  Each closed frame produces a one-cycle
//          stat_valid pulse with its length, checksum and abort flag.
// Build option: define FRAME_MONITOR_CHECKSUM_EN to build the checksum
//          accumulator; without it stat_sum is tied to zero.
// Ports:
//   clk, reset                  - single clock, synchronous active-high reset
//   in_empty/in_din/in_sof/in_eof - upstream FIFO head word and its flags
//   in_rd_en                    - pop upstream head (same cycle)
//   out_full                    - downstream FIFO full
//   out_wr_en/out_dout/out_sof/out_eof - push to downstream FIFO
//   stat_valid/stat_len/stat_sum/stat_err - registered per-frame report
//   drop_cnt                    - saturating count of discarded words

module frame_monitor
  import frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_din,
  input  logic                  in_sof,
  input  logic                  in_eof,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_dout,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  stat_valid,
  output logic [LEN_WIDTH-1:0]  stat_len,
  output logic [CSUM_WIDTH-1:0] stat_sum,
  output logic                  stat_err,
  output logic [DROP_WIDTH-1:0] drop_cnt
);

  state_t                r_state;
  state_t                w_state_next;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  w_len_next;
  logic [LEN_WIDTH-1:0]  w_len_inc;
  logic [LEN_WIDTH-1:0]  w_close_len;
  logic                  w_pop;
  logic                  w_fwd;
  logic                  w_drop;
  logic                  w_close;
  logic                  w_close_err;
  logic                  r_stat_valid;
  logic [LEN_WIDTH-1:0]  r_stat_len;
  logic                  r_stat_err;
  logic [DROP_WIDTH-1:0] r_drop_cnt;

  // Pop/forward decision.  A non-SOF head in IDLE is garbage and is drained
  // even under downstream backpressure since it never reaches the output.
  always_comb begin
    w_pop  = 1'b0;
    w_fwd  = 1'b0;
    w_drop = 1'b0;
    if (!reset && !in_empty) begin
      if (r_state == IDLE && !in_sof) begin
        w_pop  = 1'b1;
        w_drop = 1'b1;
      end else if (!out_full) begin
        w_pop = 1'b1;
        w_fwd = 1'b1;
      end
    end
  end

  assign w_len_inc = (r_len == '1) ? r_len : r_len + LEN_WIDTH'(1);

  // Frame tracking.  An SOF seen inside a frame aborts the open frame (its
  // report excludes the new word) and the new word starts the next frame.
  // If that word also carries EOF the abort is what gets reported.
  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_close      = 1'b0;
    w_close_err  = 1'b0;
    w_close_len  = r_len;
    if (w_fwd) begin
      if (in_sof) begin
        if (r_state == FRAME) begin
          w_close     = 1'b1;
          w_close_err = 1'b1;
          w_close_len = r_len;
        end else if (in_eof) begin
          w_close     = 1'b1;
          w_close_len = LEN_WIDTH'(1);
        end
        w_len_next   = LEN_WIDTH'(1);
        w_state_next = in_eof ? IDLE : FRAME;
      end else if (in_eof) begin
        w_close      = 1'b1;
        w_close_len  = w_len_inc;
        w_state_next = IDLE;
      end else begin
        w_len_next = w_len_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_stat_valid <= 1'b0;
      r_stat_len   <= '0;
      r_stat_err   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_len        <= w_len_next;
      r_stat_valid <= w_close;
      if (w_close) begin
        r_stat_len <= w_close_len;
        r_stat_err <= w_close_err;
      end
      if (w_drop && r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + DROP_WIDTH'(1);
      end
    end
  end

`ifdef FRAME_MONITOR_CHECKSUM_EN
  logic [CSUM_WIDTH-1:0] r_sum;
  logic [CSUM_WIDTH-1:0] r_stat_sum;
  logic [CSUM_WIDTH-1:0] w_din_ext;
  logic [CSUM_WIDTH-1:0] w_sum_add;
  logic [CSUM_WIDTH-1:0] w_sum_next;
  logic [CSUM_WIDTH-1:0] w_close_sum;

  assign w_din_ext = CSUM_WIDTH'(in_din);
  assign w_sum_add = r_sum + w_din_ext;

  always_comb begin
    w_sum_next  = r_sum;
    w_close_sum = w_sum_add;
    if (w_fwd) begin
      if (in_sof) begin
        w_sum_next  = w_din_ext;
        w_close_sum = (r_state == FRAME) ? r_sum : w_din_ext;
      end else begin
        w_sum_next = w_sum_add;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum      <= '0;
      r_stat_sum <= '0;
    end else begin
      r_sum <= w_sum_next;
      if (w_close) begin
        r_stat_sum <= w_close_sum;
      end
    end
  end

  assign stat_sum = r_stat_sum;
`else
  assign stat_sum = '0;
`endif

  assign in_rd_en   = w_pop;
  assign out_wr_en  = w_fwd;
  assign out_dout   = in_din;
  assign out_sof    = in_sof;
  assign out_eof    = in_eof;
  assign stat_valid = r_stat_valid;
  assign stat_len   = r_stat_len;
  assign stat_err   = r_stat_err;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_frame_monitor.sv
// tb/tb_frame_monitor.sv - directed self-checking bench for frame_monitor

module tb_frame_monitor;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] d;
  } word_t;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] sum;
    logic        err;
    int          cyc;
  } stat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_empty;
  logic [7:0]  in_din;
  logic        in_sof;
  logic        in_eof;
  logic        in_rd_en;
  logic        out_full;
  logic        out_wr_en;
  logic [7:0]  out_dout;
  logic        out_sof;
  logic        out_eof;
  logic        stat_valid;
  logic [15:0] stat_len;
  logic [15:0] stat_sum;
  logic        stat_err;
  logic [15:0] drop_cnt;

  word_t inq[$];
  word_t fwdq[$];
  stat_t statq[$];
  int    cyc;
  int    eof_cyc;
  logic  s_rd;
  logic  s_wr;
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  frame_monitor dut (
    .clk(clk), .reset(reset),
    .in_empty(in_empty), .in_din(in_din), .in_sof(in_sof), .in_eof(in_eof),
    .in_rd_en(in_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_dout(out_dout),
    .out_sof(out_sof), .out_eof(out_eof),
    .stat_valid(stat_valid), .stat_len(stat_len), .stat_sum(stat_sum),
    .stat_err(stat_err), .drop_cnt(drop_cnt)
  );

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef FRAME_MONITOR_CHECKSUM_EN
    return s;
`else
    return 16'h0 & s;
`endif
  endfunction

  task automatic drive_head();
    in_empty = (inq.size() == 0);
    if (inq.size() != 0) begin
      in_din = inq[0].d;
      in_sof = inq[0].sof;
      in_eof = inq[0].eof;
    end else begin
      in_din = 8'h00;
      in_sof = 1'b0;
      in_eof = 1'b0;
    end
  endtask

  // One clock: sample at negedge, advance upstream queue after the edge.
  task automatic step();
    logic popped;
    @(negedge clk);
    s_rd   = in_rd_en;
    s_wr   = out_wr_en;
    popped = in_rd_en;
    n_cmp++;
    if (out_wr_en && out_full) begin
      n_bad++;
      $display("FAIL wr_while_full: cycle %0d out_wr_en=1 with out_full=1", cyc);
    end
    if (out_wr_en) begin
      fwdq.push_back('{sof: out_sof, eof: out_eof, d: out_dout});
      if (out_eof) eof_cyc = cyc;
    end
    if (stat_valid) statq.push_back('{len: stat_len, sum: stat_sum, err: stat_err, cyc: cyc});
    @(posedge clk);
    #1;
    if (popped && inq.size() != 0) void'(inq.pop_front());
    cyc++;
    drive_head();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    out_full = 1'b0;
    inq.delete();
    drive_head();
    run(2);
    reset = 1'b0;
    fwdq.delete();
    statq.delete();
    cyc     = 0;
    eof_cyc = -1;
  endtask

  task automatic push(input logic sof, input logic eof, input logic [7:0] d);
    inq.push_back('{sof: sof, eof: eof, d: d});
    drive_head();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    out_full = 1'b0;
    inq.delete();
    push(1'b1, 1'b0, 8'h55);
    run(2);
    n_cmp++; if (s_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %0b expected 0", s_rd); end
    n_cmp++; if (s_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %0b expected 0", s_wr); end
    n_cmp++; if (stat_valid !== 1'b0) begin n_bad++; $display("FAIL reset_stat_valid: got %0b expected 0", stat_valid); end
    n_cmp++; if (stat_len !== 16'h0) begin n_bad++; $display("FAIL reset_stat_len: got %0h expected 0", stat_len); end
    n_cmp++; if (stat_sum !== 16'h0) begin n_bad++; $display("FAIL reset_stat_sum: got %0h expected 0", stat_sum); end
    n_cmp++; if (stat_err !== 1'b0) begin n_bad++; $display("FAIL reset_stat_err: got %0b expected 0", stat_err); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0h expected 0", drop_cnt); end
    reset = 1'b0;
    inq.delete();
    drive_head();
  endtask

  task automatic test_basic();
    word_t exp[4];
    do_reset();
    exp[0] = '{sof: 1'b1, eof: 1'b0, d: 8'h01};
    exp[1] = '{sof: 1'b0, eof: 1'b0, d: 8'h10};
    exp[2] = '{sof: 1'b0, eof: 1'b0, d: 8'h20};
    exp[3] = '{sof: 1'b0, eof: 1'b1, d: 8'h30};
    for (int i = 0; i < 4; i++) push(exp[i].sof, exp[i].eof, exp[i].d);
    run(8);
    n_cmp++; if (fwdq.size() != 4) begin n_bad++; $display("FAIL basic_fwd_count: got %0d expected 4", fwdq.size()); end
    for (int i = 0; i < 4 && i < fwdq.size(); i++) begin
      n_cmp++; if (fwdq[i] !== exp[i]) begin n_bad++; $display("FAIL basic_word%0d: got %0h expected %0h", i, fwdq[i], exp[i]); end
    end
    n_cmp++;
    if (statq.size() != 1) begin
      n_bad++; $display("FAIL basic_stat_count: got %0d expected 1", statq.size());
    end else begin
      n_cmp++; if (statq[0].cyc != eof_cyc + 1) begin n_bad++; $display("FAIL basic_stat_timing: got cycle %0d expected %0d", statq[0].cyc, eof_cyc + 1); end
      n_cmp++; if (statq[0].len !== 16'd4) begin n_bad++; $display("FAIL basic_len: got %0d expected 4", statq[0].len); end
      n_cmp++; if (statq[0].sum !== exp_sum(16'h0061)) begin n_bad++; $display("FAIL basic_sum: got %0h expected %0h", statq[0].sum, exp_sum(16'h0061)); end
      n_cmp++; if (statq[0].err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %0b expected 0", statq[0].err); end
    end
    n_cmp++; if (stat_len !== 16'd4 || stat_valid !== 1'b0) begin n_bad++; $display("FAIL basic_hold: got len %0d valid %0b expected len 4 valid 0", stat_len, stat_valid); end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 8'hAA);
    push(1'b1, 1'b0, 8'h01);
    push(1'b0, 1'b1, 8'h02);
    run(8);
    n_cmp++; if (drop_cnt !== 16'd3) begin n_bad++; $display("FAIL drop_cnt: got %0d expected 3", drop_cnt); end
    n_cmp++;
    if (fwdq.size() != 2) begin
      n_bad++; $display("FAIL drop_fwd_count: got %0d expected 2", fwdq.size());
    end else begin
      n_cmp++; if (fwdq[0] !== {1'b1, 1'b0, 8'h01} || fwdq[1] !== {1'b0, 1'b1, 8'h02}) begin n_bad++; $display("FAIL drop_fwd_data: got %0h %0h expected 201 102", fwdq[0], fwdq[1]); end
    end
    n_cmp++; if (statq.size() != 1 || statq[0].len !== 16'd2) begin n_bad++; $display("FAIL drop_stat: got %0d pulses expected 1 with len 2", statq.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int viol = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push(i == 0, i == 4, d[i]);
    run(2);
    out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_rd !== 1'b0 || s_wr !== 1'b0) viol++;
    end
    out_full = 1'b0;
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL bp_stall: got %0d cycles with pop/push expected 0", viol); end
    run(8);
    n_cmp++;
    if (fwdq.size() != 5) begin
      n_bad++; $display("FAIL bp_fwd_count: got %0d expected 5", fwdq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (fwdq[i].d !== d[i]) begin n_bad++; $display("FAIL bp_word%0d: got %0h expected %0h", i, fwdq[i].d, d[i]); end
      end
    end
    n_cmp++; if (statq.size() != 1 || statq[0].len !== 16'd5 || statq[0].sum !== exp_sum(16'h00FF)) begin n_bad++; $display("FAIL bp_stat: got %0d pulses expected 1 with len 5 sum %0h", statq.size(), exp_sum(16'h00FF)); end
  endtask

  task automatic test_abort();
    do_reset();
    push(1'b1, 1'b0, 8'h01); push(1'b0, 1'b0, 8'h02); push(1'b0, 1'b0, 8'h03);
    push(1'b1, 1'b0, 8'h04); push(1'b0, 1'b0, 8'h05); push(1'b0, 1'b1, 8'h06);
    run(10);
    n_cmp++;
    if (statq.size() != 2) begin
      n_bad++; $display("FAIL abort_stat_count: got %0d expected 2", statq.size());
    end else begin
      n_cmp++; if (statq[0].err !== 1'b1 || statq[0].len !== 16'd3) begin n_bad++; $display("FAIL abort_first: got err %0b len %0d expected err 1 len 3", statq[0].err, statq[0].len); end
      n_cmp++; if (statq[0].sum !== exp_sum(16'h0006)) begin n_bad++; $display("FAIL abort_first_sum: got %0h expected %0h", statq[0].sum, exp_sum(16'h0006)); end
      n_cmp++; if (statq[1].err !== 1'b0 || statq[1].len !== 16'd3) begin n_bad++; $display("FAIL abort_second: got err %0b len %0d expected err 0 len 3", statq[1].err, statq[1].len); end
      n_cmp++; if (statq[1].sum !== exp_sum(16'h000F)) begin n_bad++; $display("FAIL abort_second_sum: got %0h expected %0h", statq[1].sum, exp_sum(16'h000F)); end
    end
    n_cmp++; if (fwdq.size() != 6) begin n_bad++; $display("FAIL abort_fwd_count: got %0d expected 6", fwdq.size()); end
  endtask

  task automatic test_single();
    do_reset();
    push(1'b1, 1'b1, 8'h7F);
    push(1'b0, 1'b0, 8'h99);
    run(6);
    n_cmp++;
    if (statq.size() != 1) begin
      n_bad++; $display("FAIL single_stat_count: got %0d expected 1", statq.size());
    end else begin
      n_cmp++; if (statq[0].len !== 16'd1 || statq[0].err !== 1'b0) begin n_bad++; $display("FAIL single_len: got len %0d err %0b expected len 1 err 0", statq[0].len, statq[0].err); end
      n_cmp++; if (statq[0].sum !== exp_sum(16'h007F)) begin n_bad++; $display("FAIL single_sum: got %0h expected %0h", statq[0].sum, exp_sum(16'h007F)); end
    end
    n_cmp++; if (drop_cnt !== 16'd1 || fwdq.size() != 1) begin n_bad++; $display("FAIL single_idle: got drop %0d fwd %0d expected drop 1 fwd 1", drop_cnt, fwdq.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(1'b1, 1'b0, 8'h01); push(1'b0, 1'b0, 8'h02);
    push(1'b0, 1'b0, 8'h03); push(1'b0, 1'b1, 8'h04);
    run(2);
    reset = 1'b1;
    step();
    n_cmp++; if (s_rd !== 1'b0 || s_wr !== 1'b0) begin n_bad++; $display("FAIL rstmid_io: got rd %0b wr %0b expected 0 0", s_rd, s_wr); end
    step();
    reset = 1'b0;
    n_cmp++; if (stat_valid !== 1'b0 || stat_len !== 16'h0 || stat_err !== 1'b0 || stat_sum !== 16'h0 || drop_cnt !== 16'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got valid %0b len %0h err %0b sum %0h drop %0h expected all 0", stat_valid, stat_len, stat_err, stat_sum, drop_cnt);
    end
    run(6);
    push(1'b1, 1'b0, 8'h09);
    push(1'b0, 1'b1, 8'h0A);
    run(6);
    n_cmp++;
    if (statq.size() != 1) begin
      n_bad++; $display("FAIL rstmid_stat_count: got %0d expected 1", statq.size());
    end else begin
      n_cmp++; if (statq[0].len !== 16'd2 || statq[0].err !== 1'b0) begin n_bad++; $display("FAIL rstmid_len: got len %0d err %0b expected len 2 err 0", statq[0].len, statq[0].err); end
      n_cmp++; if (statq[0].sum !== exp_sum(16'h0013)) begin n_bad++; $display("FAIL rstmid_sum: got %0h expected %0h", statq[0].sum, exp_sum(16'h0013)); end
    end
    n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL rstmid_drop: got %0d expected 2", drop_cnt); end
  endtask

  initial begin
    reset    = 1'b1;
    out_full = 1'b0;
    in_empty = 1'b1;
    in_din   = 8'h00;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    cyc      = 0;
    eof_cyc  = -1;
    s_rd     = 1'b0;
    s_wr     = 1'b0;
    test_reset();
    test_basic();
    test_drop();
    test_backpressure();
    test_abort();
    test_single();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
